// File: rtl/mdio_mgmt_ctrl.sv
// Clause 22 MDIO master: divides clk into MDC and serialises one read/write register frame per request.
// Outputs are registered; read data and turnaround error return with a one-cycle done pulse.
module mdio_mgmt_ctrl #(
    parameter int CLK_DIV = 50,
    parameter int PRE_LEN = 32
) (
    input  logic        clk,
    input  logic        I_rst_n,
    input  logic        I_req,
    input  logic        I_wr,
    input  logic [4:0]  I_phy_addr,
    input  logic [4:0]  I_reg_addr,
    input  logic [15:0] I_wdata,
    output logic        O_busy,
    output logic        O_done,
    output logic [15:0] O_rdata,
    output logic        O_rd_err,
    output logic        O_phy_mdc,
    output logic        O_mdio_out,
    output logic        O_mdio_oe,
    input  logic        I_mdio_in
);
    localparam int DW      = $clog2(2 * CLK_DIV);
    localparam int CNT_MAX = (PRE_LEN > 16) ? PRE_LEN : 16;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);
    localparam logic [CW-1:0] PRE_LAST = CW'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_TA   = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;
    localparam logic [2:0] S_END  = 3'd5;

    logic [2:0]    state_q, state_d, state_nxt;
    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_last;
    logic          wr_q, wr_d;
    logic [4:0]    phy_q, phy_d, reg_q, reg_d;
    logic [15:0]   wdata_q, wdata_d, rx_q, rx_d, rdata_q, rdata_d;
    logic          busy_q, busy_d, done_q, done_d, rd_err_q, rd_err_d;
    logic          mdc_q, mdc_d, mdio_out_q, mdio_out_d, mdio_oe_q, mdio_oe_d;
    logic [13:0]   hdr;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        phy_d    = phy_q;
        reg_d    = reg_q;
        wdata_d  = wdata_q;
        rx_d     = rx_q;
        rdata_d  = rdata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rd_err_d = rd_err_q;

        cnt_last  = '0;
        state_nxt = S_IDLE;
        case (state_q)
            S_PRE:   begin cnt_last = PRE_LAST;  state_nxt = S_HDR;  end
            S_HDR:   begin cnt_last = CW'(13);   state_nxt = S_TA;   end
            S_TA:    begin cnt_last = CW'(1);    state_nxt = S_DATA; end
            S_DATA:  begin cnt_last = CW'(15);   state_nxt = S_END;  end
            default: begin cnt_last = '0;        state_nxt = S_IDLE; end
        endcase

        if (state_q == S_IDLE) begin
            if (I_req) begin
                wr_d     = I_wr;
                phy_d    = I_phy_addr;
                reg_d    = I_reg_addr;
                wdata_d  = I_wdata;
                rd_err_d = 1'b0;
                busy_d   = 1'b1;
                div_d    = '0;
                cnt_d    = '0;
                state_d  = (PRE_LEN > 0) ? S_PRE : S_HDR;
            end
        end else begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            // Input is sampled on the last high-phase cycle, just before MDC falls.
            if (div_q == DIV_LAST) begin
                if (!wr_q && state_q == S_TA && cnt_q == CW'(1)) rd_err_d = I_mdio_in;
                if (!wr_q && state_q == S_DATA) rx_d = {rx_q[14:0], I_mdio_in};
                if (cnt_q == cnt_last) begin
                    state_d = state_nxt;
                    cnt_d   = '0;
                    if (state_q == S_END) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        if (!wr_q) rdata_d = rx_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // Pin values are derived from the next state so they change with MDC's falling edge.
    always_comb begin
        hdr        = {2'b01, (wr_d ? 2'b01 : 2'b10), phy_d, reg_d};
        mdio_out_d = 1'b0;
        mdio_oe_d  = 1'b0;
        mdc_d      = (state_d != S_IDLE) && (div_d >= DIV_HALF);
        case (state_d)
            S_PRE:  begin mdio_out_d = 1'b1; mdio_oe_d = 1'b1; end
            S_HDR:  begin mdio_out_d = hdr[4'd13 - cnt_d[3:0]]; mdio_oe_d = 1'b1; end
            S_TA:   begin mdio_out_d = wr_d && (cnt_d == '0); mdio_oe_d = wr_d; end
            S_DATA: begin mdio_out_d = wr_d && wdata_d[4'd15 - cnt_d[3:0]]; mdio_oe_d = wr_d; end
            default: begin mdio_out_d = 1'b0; mdio_oe_d = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            phy_q      <= '0;
            reg_q      <= '0;
            wdata_q    <= '0;
            rx_q       <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_err_q   <= 1'b0;
            mdc_q      <= 1'b0;
            mdio_out_q <= 1'b0;
            mdio_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            phy_q      <= phy_d;
            reg_q      <= reg_d;
            wdata_q    <= wdata_d;
            rx_q       <= rx_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_err_q   <= rd_err_d;
            mdc_q      <= mdc_d;
            mdio_out_q <= mdio_out_d;
            mdio_oe_q  <= mdio_oe_d;
        end
    end

    assign O_busy     = busy_q;
    assign O_done     = done_q;
    assign O_rdata    = rdata_q;
    assign O_rd_err   = rd_err_q;
    assign O_phy_mdc  = mdc_q;
    assign O_mdio_out = mdio_out_q;
    assign O_mdio_oe  = mdio_oe_q;
endmodule
